fifo_read_arbiter: RTL
======================

Name: fifo_read_arbiter

Overview:
- Shares the single read port of the hasher's async FIFO among NREQ consumers, all in the read clock domain.
- Arbitrates on consumer request, then grants one consumer a burst of up to BURST words.
- Drives the FIFO read-increment from a valid/ready handshake. Releases the grant on burst completion, FIFO empty or request drop.
- Sits between the FIFO read-pointer/empty logic and the downstream consumers (hash engine, I2C readback).

Parameters:
- NREQ, 2, number of consumers (2..8).
- DATA_WIDTH, 8, FIFO word width.
- BURST, 4, maximum words transferred per grant (>=1).

Ports:
- rclk  input  1  read-domain clock; all logic on rising edge.
- rrst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-consumer request; level, held while the consumer wants data.
- rdy  input  NREQ  per-consumer ready; only the granted consumer's bit is honoured.
- fifo_rempty  input  1  registered FIFO empty flag; updates on the edge after fifo_rinc.
- fifo_rdata  input  DATA_WIDTH  FIFO head word; valid whenever fifo_rempty=0.
- fifo_rinc  output  1  read-increment to the FIFO; combinational.
- gnt  output  NREQ  one-hot grant, registered; all zeros when idle.
- out_valid  output  1  broadcast data valid.
- out_data  output  DATA_WIDTH  broadcast data, equal to fifo_rdata.
- out_last  output  1  marks the final word of the current burst.

Behaviour:
- Reset (rrst=1 at a rclk edge): state=IDLE, gnt=0, count=0, rr_last=NREQ-1.
  - While rrst is high, fifo_rinc, out_valid and out_last are forced to 0.
  - Reset mid-burst abandons the burst. No word is lost, because fifo_rinc was never asserted for the unread word.
- States: IDLE, XFER.
- IDLE:
  - gnt=0, out_valid=0, fifo_rinc=0.
  - If |req and fifo_rempty=0: choose a winner, then on the next edge gnt=onehot(winner), rr_last=winner, count=0, state=XFER.
  - Otherwise stay in IDLE.
- Round-robin winner: the first requester with req set, searching from index rr_last+1 upward modulo NREQ. After reset, requester 0 wins first.
- XFER, with g = the granted index:
  - out_valid = ~fifo_rempty.
  - out_data = fifo_rdata.
  - fire = out_valid & rdy[g] & req[g].
  - fifo_rinc = fire.
  - out_last = out_valid & (count==BURST-1).
  - On fire, count increments.
- XFER to IDLE (gnt cleared on the same edge) on any of:
  - fire with count==BURST-1;
  - req[g]=0;
  - fifo_rempty=1.
- Re-arbitration: leaving XFER always passes through IDLE for at least one cycle.
  - Back-to-back grants therefore have a one-cycle bubble.
  - Request-to-first-valid latency is 1 cycle from IDLE.
- Simultaneous events:
  - req[g] dropping in the same cycle as rdy[g]=1: no fire, release. A consumer must keep req high through its last accepted word.
  - The last fire of a burst and fifo_rempty rising on the next edge: normal release, no extra read.
  - rdy on non-granted consumers is ignored.
- count width is clog2(BURST)+1 and never exceeds BURST-1.
- fifo_rinc is never asserted when fifo_rempty=1.

Optional Feature:
- Macro: FIFO_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_last is removed; all other behaviour is unchanged.
- Undefined (default): round-robin as above.

Test Plan:
- Reset, then req=2'b01, FIFO holds 6 words (0xA0..0xA5), rdy=1 → gnt=01 one cycle later; 0xA0..0xA3 fire on consecutive cycles with out_last on 0xA3; one-cycle IDLE bubble; regrant; 0xA4, 0xA5; release on empty; fifo_rinc pulses total exactly 6.
- req=2'b11 held, FIFO kept non-empty → grants alternate 0,1,0,1, each 4 words. With FIFO_ARB_FIXED_PRIO_EN → consumer 0 granted every time.
- Granted consumer toggles rdy 1,0,1,0 → fifo_rinc only on rdy=1 cycles; out_data holds the same word while rdy=0.
- req[g] dropped after 2 words of a burst → release next edge, gnt=0, count=0; remaining words stay in the FIFO; another requester is granted after the IDLE cycle.
- FIFO empty with req=2'b01 → gnt stays 0, fifo_rinc stays 0; FIFO becomes non-empty → grant next edge.
- rrst asserted mid-burst after 2 fires → gnt=0 and fifo_rinc=0 next cycle; after reset requester 0 wins first; the next word delivered is the third FIFO word.

Source files
------------

// File: rtl/fifo_read_arbiter.sv
// Shares one async-FIFO read port among NREQ read-domain consumers, granting bursts of up to BURST words.
// Define FIFO_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module fifo_read_arbiter #(
    parameter int NREQ       = 2,
    parameter int DATA_WIDTH = 8,
    parameter int BURST      = 4
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       rdy,
    input  logic                  fifo_rempty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rinc,
    output logic [NREQ-1:0]       gnt,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BURST) + 1;

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [NREQ-1:0] gnt_next;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   gidx_next;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            winner_found;
    logic [IW-1:0]   winner;
    logic            fire;
    logic            last_word;

`ifndef FIFO_ARB_FIXED_PRIO_EN
    logic [IW-1:0]   rr_last;
    logic [IW-1:0]   rr_last_next;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction
`endif

    // Descending scan so the highest-priority candidate is assigned last.
    always_comb begin
        winner_found = 1'b0;
        winner       = '0;
`ifdef FIFO_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[IW'(i)]) begin
                winner_found = 1'b1;
                winner       = IW'(i);
            end
        end
`else
        for (int k = NREQ; k >= 1; k--) begin
            if (req[wrap_idx(rr_last, k)]) begin
                winner_found = 1'b1;
                winner       = wrap_idx(rr_last, k);
            end
        end
`endif
    end

    assign last_word = (count == CW'(BURST - 1));
    assign fire      = (state == XFER) & ~fifo_rempty & req[gidx] & rdy[gidx] & ~rrst;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state   <= IDLE;
            gnt     <= '0;
            gidx    <= '0;
            count   <= '0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
            rr_last <= IW'(NREQ - 1);
`endif
        end else begin
            state   <= state_next;
            gnt     <= gnt_next;
            gidx    <= gidx_next;
            count   <= count_next;
`ifndef FIFO_ARB_FIXED_PRIO_EN
            rr_last <= rr_last_next;
`endif
        end
    end

    always_comb begin
        state_next   = state;
        gnt_next     = gnt;
        gidx_next    = gidx;
        count_next   = count;
`ifndef FIFO_ARB_FIXED_PRIO_EN
        rr_last_next = rr_last;
`endif
        case (state)
            IDLE: begin
                if (winner_found && !fifo_rempty) begin
                    state_next   = XFER;
                    gnt_next     = {{(NREQ-1){1'b0}}, 1'b1} << winner;
                    gidx_next    = winner;
                    count_next   = '0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
                    rr_last_next = winner;
`endif
                end
            end
            XFER: begin
                // Any release goes through IDLE, which gives the one-cycle re-arbitration bubble.
                if ((fire && last_word) || !req[gidx] || fifo_rempty) begin
                    state_next = IDLE;
                    gnt_next   = '0;
                    count_next = '0;
                end else if (fire) begin
                    count_next = count + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
                count_next = '0;
            end
        endcase
    end

    always_comb begin
        fifo_rinc = fire;
        out_data  = fifo_rdata;
        out_valid = 1'b0;
        out_last  = 1'b0;
        if (state == XFER && !rrst) begin
            out_valid = ~fifo_rempty;
            out_last  = ~fifo_rempty & last_word;
        end
    end

endmodule
